// File: rtl/div_detect_pkg.sv
// Shared types and limits for the divided-clock decoder.
// Legal divider range is 2..7, with a high phase of floor(N/2) cycles.
package div_detect_pkg;

   typedef enum logic [1:0] {
      IDLE,
      HIGH,
      LOW
   } state_t;

   localparam logic [2:0] MIN_DIV  = 3'd2;
   localparam logic [2:0] MAX_DIV  = 3'd7;
   localparam logic [2:0] MAX_HIGH = 3'd3;
   localparam logic [2:0] MAX_LOW  = 3'd4;

   function automatic logic [2:0] expected_high(input logic [3:0] p);
      return p[3:1];
   endfunction

endpackage

// File: rtl/div_detector_lock_tracker.sv
// Holds the last decoded divider and counts consecutive identical
// well-formed periods to produce the lock flag.
module lock_tracker
   import div_detect_pkg::*;
#(
   parameter int unsigned LOCK_COUNT = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       i_close,
   input  logic       i_wf,
   input  logic [2:0] i_p,
   output logic [2:0] o_div,
   output logic       o_locked
);

   localparam logic [2:0] LC = 3'(LOCK_COUNT);

   logic [2:0] r_div;
   logic [2:0] r_streak;
   logic       r_locked;
   logic [2:0] w_streak_nxt;

   always_comb begin
      w_streak_nxt = 3'd1;
      if (r_streak != '0 && i_p == r_div) begin
         if (r_streak >= LC) w_streak_nxt = LC;
         else                w_streak_nxt = r_streak + 3'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_div    <= '0;
         r_streak <= '0;
         r_locked <= 1'b0;
      end else if (i_close) begin
         if (i_wf) begin
            r_div    <= i_p;
            r_streak <= w_streak_nxt;
            r_locked <= (w_streak_nxt == LC);
         end else begin
            // Malformed periods and timeouts both break the streak; div_out holds.
            r_streak <= '0;
            r_locked <= 1'b0;
         end
      end
   end

   assign o_div    = r_div;
   assign o_locked = r_locked;

endmodule

// File: rtl/div_detector.sv
// Recovers N from a div-by-N waveform sampled in the clk domain; flags
// each well-formed period, malformed shapes and stuck phases.
module div_detector
   import div_detect_pkg::*;
#(
   parameter int unsigned LOCK_COUNT = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       q_in,
   output logic [2:0] div_out,
   output logic       valid,
   output logic       err,
   output logic       locked
);

   state_t     r_state;
   state_t     w_state_nxt;
   logic       r_q_d;
   logic [2:0] r_hcnt;
   logic [2:0] r_lcnt;
   logic [2:0] w_hcnt_nxt;
   logic [2:0] w_lcnt_nxt;
   logic       r_valid;
   logic       r_err;
   logic       w_valid_nxt;
   logic       w_err_nxt;
   logic       w_rise;
   logic       w_fall;
   logic       w_close;
   logic       w_timeout;
   logic       w_wf;
   logic [3:0] w_p;

   assign w_rise = q_in & ~r_q_d;
   assign w_fall = ~q_in & r_q_d;
   assign w_p    = {1'b0, r_hcnt} + {1'b0, r_lcnt};
   assign w_wf   = (w_p >= {1'b0, MIN_DIV}) && (w_p <= {1'b0, MAX_DIV}) &&
                   (r_hcnt == expected_high(w_p));

   always_comb begin
      w_state_nxt = r_state;
      w_hcnt_nxt  = r_hcnt;
      w_lcnt_nxt  = r_lcnt;
      w_valid_nxt = 1'b0;
      w_err_nxt   = 1'b0;
      w_close     = 1'b0;
      w_timeout   = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_rise) begin
               w_state_nxt = HIGH;
               w_hcnt_nxt  = 3'd1;
               w_lcnt_nxt  = '0;
            end
         end
         HIGH: begin
            // Timeout wins over any edge seen in the same cycle.
            if (r_hcnt == MAX_HIGH + 3'd1) begin
               w_timeout   = 1'b1;
               w_err_nxt   = 1'b1;
               w_state_nxt = IDLE;
               w_hcnt_nxt  = '0;
               w_lcnt_nxt  = '0;
            end else if (w_fall) begin
               w_state_nxt = LOW;
               w_lcnt_nxt  = 3'd1;
            end else begin
               w_hcnt_nxt  = r_hcnt + 3'd1;
            end
         end
         LOW: begin
            if (r_lcnt == MAX_LOW + 3'd1) begin
               w_timeout   = 1'b1;
               w_err_nxt   = 1'b1;
               w_state_nxt = IDLE;
               w_hcnt_nxt  = '0;
               w_lcnt_nxt  = '0;
            end else if (w_rise) begin
               w_close     = 1'b1;
               w_valid_nxt = w_wf;
               w_err_nxt   = ~w_wf;
               w_state_nxt = HIGH;
               w_hcnt_nxt  = 3'd1;
               w_lcnt_nxt  = '0;
            end else begin
               w_lcnt_nxt  = r_lcnt + 3'd1;
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_hcnt_nxt  = '0;
            w_lcnt_nxt  = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_q_d   <= 1'b1;
         r_hcnt  <= '0;
         r_lcnt  <= '0;
         r_valid <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_q_d   <= q_in;
         r_hcnt  <= w_hcnt_nxt;
         r_lcnt  <= w_lcnt_nxt;
         r_valid <= w_valid_nxt;
         r_err   <= w_err_nxt;
      end
   end

   lock_tracker #(
      .LOCK_COUNT(LOCK_COUNT)
   ) u_lock (
      .clk      (clk),
      .rst      (rst),
      .i_close  (w_close | w_timeout),
      .i_wf     (w_close & w_wf),
      .i_p      (w_p[2:0]),
      .o_div    (div_out),
      .o_locked (locked)
   );

   assign valid = r_valid;
   assign err   = r_err;

endmodule

// File: tb/tb_div_detector.sv
// Scoreboard bench for div_detector: waveforms are built per reset segment,
// a run-length reference model predicts every valid/err event.
module tb_div_detector;

   localparam int unsigned LC = 2;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       q_in = 1'b0;
   logic [2:0] div_out;
   logic       valid;
   logic       err;
   logic       locked;

   div_detector #(
      .LOCK_COUNT(LC)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .q_in    (q_in),
      .div_out (div_out),
      .valid   (valid),
      .err     (err),
      .locked  (locked)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int unsigned at;
      bit          is_valid;
      int          div;
      bit          lck;
   } exp_t;

   exp_t sb[$];
   bit   stim[$];
   int   n_checks = 0;
   int   n_fail = 0;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s @cycle %0d: got %0d expected %0d", name, cyc, act, exp);
      end
   endtask

   // Monitor: retire overdue expectations, then match any pulse the DUT shows.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         while (sb.size() > 0 && sb[0].at < cyc) begin
            e = sb.pop_front();
            n_checks++;
            n_fail++;
            $display("FAIL missing_event: expected %s at cycle %0d, still pending at cycle %0d",
                     e.is_valid ? "valid" : "err", e.at, cyc);
         end
         if (valid || err) begin
            if (sb.size() > 0 && sb[0].at == cyc) begin
               e = sb.pop_front();
               check("valid", int'(valid), int'(e.is_valid));
               check("err", int'(err), int'(!e.is_valid));
               check("div_out", int'(div_out), e.div);
               check("locked", int'(locked), int'(e.lck));
            end else begin
               n_checks++;
               n_fail++;
               $display("FAIL spurious_event @cycle %0d: valid=%0b err=%0b, expected none",
                        cyc, valid, err);
            end
         end
      end
   end

   task automatic add_run(input bit v, input int k);
      repeat (k) stim.push_back(v);
   endtask

   task automatic add_period(input int n);
      add_run(1'b1, n / 2);
      add_run(1'b0, n - n / 2);
   endtask

   function automatic int find_rise(input int from);
      bit p;
      for (int j = from; j < stim.size(); j++) begin
         p = (j == 0) ? 1'b1 : stim[j-1];
         if (stim[j] && !p) return j;
      end
      return -1;
   endfunction

   function automatic bit lock_of(input int hist[$]);
      int sz = hist.size();
      if (sz < int'(LC)) return 1'b0;
      for (int k = 0; k < int'(LC); k++)
         if (hist[sz-1-k] == 0 || hist[sz-1-k] != hist[sz-1]) return 1'b0;
      return 1'b1;
   endfunction

   // Sample index e produces an output visible at the negedge where cyc == c0+e+1.
   task automatic model_segment(input int unsigned c0);
      int   n = stim.size();
      int   s, h, l, e, p;
      int   hist[$];
      int   last_div = 0;
      exp_t x;
      s = find_rise(0);
      while (s >= 0) begin
         h = 0;
         while (s + h < n && stim[s+h]) h++;
         if (h >= 4) begin
            e = s + 4;
            if (e >= n) break;
            hist.push_back(0);
            x = '{at: c0 + e + 1, is_valid: 1'b0, div: last_div, lck: lock_of(hist)};
            sb.push_back(x);
            s = find_rise(e + 1);
            continue;
         end
         if (s + h >= n) break;
         l = 0;
         while (s + h + l < n && !stim[s+h+l]) l++;
         if (l >= 5) begin
            e = s + h + 5;
            if (e >= n) break;
            hist.push_back(0);
            x = '{at: c0 + e + 1, is_valid: 1'b0, div: last_div, lck: lock_of(hist)};
            sb.push_back(x);
            s = find_rise(e + 1);
            continue;
         end
         if (s + h + l >= n) break;
         e = s + h + l;
         p = h + l;
         if (p >= 2 && p <= 7 && h == p / 2) begin
            last_div = p;
            hist.push_back(p);
            x = '{at: c0 + e + 1, is_valid: 1'b1, div: last_div, lck: lock_of(hist)};
         end else begin
            hist.push_back(0);
            x = '{at: c0 + e + 1, is_valid: 1'b0, div: last_div, lck: lock_of(hist)};
         end
         sb.push_back(x);
         s = e;
      end
   endtask

   // Entered and left on a negedge; releases reset on the first sample.
   task automatic run_segment();
      int unsigned c0 = cyc;
      model_segment(c0);
      rst = 1'b0;
      foreach (stim[i]) begin
         if (i > 0) @(negedge clk);
         q_in = stim[i];
      end
      stim.delete();
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst  = 1'b1;
      q_in = 1'($urandom);
      @(negedge clk);
      check("rst_div_out", int'(div_out), 0);
      check("rst_locked", int'(locked), 0);
      check("rst_valid", int'(valid), 0);
      check("rst_err", int'(err), 0);
      @(negedge clk);
   endtask

   initial begin
      int divs[5] = '{2, 3, 4, 6, 7};
      int r;

      do_reset();

      // N = 5 stream
      add_run(1'b0, 3);
      repeat (6) add_period(5);
      add_run(1'b1, 1);
      run_segment();
      do_reset();

      // Sweep with clean transitions
      add_run(1'b0, 2);
      foreach (divs[i]) repeat (4) add_period(divs[i]);
      add_run(1'b1, 1);
      run_segment();
      do_reset();

      // Malformed period (high 1, low 3) between good N = 5 periods
      add_run(1'b0, 2);
      repeat (3) add_period(5);
      add_run(1'b1, 1);
      add_run(1'b0, 3);
      repeat (3) add_period(5);
      add_run(1'b1, 1);
      run_segment();
      do_reset();

      // Stuck high then stuck low
      add_run(1'b0, 2);
      add_run(1'b1, 10);
      add_run(1'b0, 10);
      run_segment();
      do_reset();

      // Locked N = 6 stream, reset mid-period, then resume mid-phase
      add_run(1'b0, 2);
      repeat (4) add_period(6);
      add_run(1'b1, 2);
      run_segment();
      @(negedge clk);
      check("locked_before_reset", int'(locked), 1);
      check("div_before_reset", int'(div_out), 6);
      do_reset();
      add_run(1'b1, 1);
      add_run(1'b0, 2);
      repeat (3) add_period(6);
      add_run(1'b1, 1);
      run_segment();
      do_reset();

      // Reset released while the input is already high
      add_run(1'b1, 3);
      repeat (4) add_period(4);
      add_run(1'b1, 1);
      run_segment();
      do_reset();

      // Randomized mixes of good periods, odd runs and stuck phases
      repeat (20) begin
         add_run(1'($urandom), $urandom_range(0, 3));
         repeat (12) begin
            r = $urandom_range(0, 9);
            if (r < 6) begin
               repeat ($urandom_range(1, 4)) add_period($urandom_range(2, 7));
            end else if (r < 8) begin
               add_run(1'b1, $urandom_range(1, 5));
               add_run(1'b0, $urandom_range(1, 6));
            end else begin
               add_run(1'($urandom), $urandom_range(4, 9));
            end
         end
         run_segment();
         do_reset();
      end

      repeat (3) @(negedge clk);
      check("scoreboard_drained", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
